// File: rtl/huffman_pkg.sv
// huffman_pkg: shared sizes, FSM encoding, saturation limit and length helper for the Huffman decoder.
package huffman_pkg;
  localparam int SYMS = 10;
  localparam int CW = 9;
  localparam logic [8:0] SYM_MAX = 9'd511;
  typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} state_t;
  function automatic logic [3:0] popcount(input logic [CW-1:0] m);
    return 4'($countones(m));
  endfunction
endpackage

// File: rtl/huffman_code_match.sv
// huffman_code_match: finds the lowest table entry whose code equals the bits collected so far.
module huffman_code_match #(
  parameter int SYMS = huffman_pkg::SYMS,
  parameter int CW = huffman_pkg::CW
) (
  input  logic [CW-1:0] sh,
  input  logic [3:0] cnt,
  input  logic [SYMS-1:0][CW-1:0] codes,
  input  logic [SYMS-1:0][CW-1:0] masks,
  input  logic [SYMS-1:0][3:0] lens,
  output logic hit,
  output logic [3:0] idx
);
  import huffman_pkg::*;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = SYMS - 1; k >= 0; k--)
      if (masks[k] != '0 && lens[k] == cnt && (sh & masks[k]) == (codes[k] & masks[k])) begin
        hit = 1'b1;
        idx = 4'(k);
      end
  end
endmodule

// File: rtl/huffman_decoding.sv
// huffman_decoding: serial prefix-code decoder with a loadable code table and stream framing.
module huffman_decoding #(
  parameter int SYMS = huffman_pkg::SYMS,
  parameter int CW = huffman_pkg::CW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic table_load,
  input  logic [CW-1:0] code_0, code_1, code_2, code_3, code_4,
  input  logic [CW-1:0] code_5, code_6, code_7, code_8, code_9,
  input  logic [CW-1:0] code_mask_0, code_mask_1, code_mask_2, code_mask_3, code_mask_4,
  input  logic [CW-1:0] code_mask_5, code_mask_6, code_mask_7, code_mask_8, code_mask_9,
  input  logic in_start,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_gap,
  input  logic in_done,
  output logic [3:0] sym_out,
  output logic sym_valid,
  output logic [8:0] sym_count,
  output logic decode_done,
  output logic decode_error
);
  import huffman_pkg::*;
  logic [9:0][CW-1:0] code_in, mask_in;
  logic [SYMS-1:0][CW-1:0] codes, masks;
  logic [SYMS-1:0][3:0] lens;
  logic [CW-1:0] sh, sh_nx;
  logic [3:0] cnt, cnt_nx, cnt_eff, idx;
  logic hit, fire, err, table_valid;
  state_t state;
  assign code_in = {code_9, code_8, code_7, code_6, code_5, code_4, code_3, code_2, code_1, code_0};
  assign mask_in = {code_mask_9, code_mask_8, code_mask_7, code_mask_6, code_mask_5,
                    code_mask_4, code_mask_3, code_mask_2, code_mask_1, code_mask_0};
  // The incoming bit is folded in first so gap/done see the post-bit count.
  assign sh_nx = in_valid ? {sh[CW-2:0], in_data} : sh;
  assign cnt_nx = in_valid ? cnt + 4'd1 : cnt;
  assign fire = in_valid && hit;
  assign cnt_eff = fire ? '0 : cnt_nx;
  assign err = (in_valid && !hit && cnt_nx == 4'(CW)) || ((in_gap || in_done) && cnt_eff != '0);
  huffman_code_match #(.SYMS(SYMS), .CW(CW)) u_match (
    .sh(sh_nx), .cnt(cnt_nx), .codes(codes), .masks(masks), .lens(lens), .hit(hit), .idx(idx)
  );
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      table_valid <= 1'b0;
      codes <= '0;
      masks <= '0;
      lens <= '0;
      sh <= '0;
      cnt <= '0;
      sym_out <= '0;
      sym_valid <= 1'b0;
      sym_count <= '0;
      decode_done <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      if (state != RECV) begin
        if (table_load) begin
          table_valid <= 1'b1;
          for (int k = 0; k < SYMS; k++) begin
            codes[k] <= code_in[k % 10];
            masks[k] <= mask_in[k % 10];
            lens[k] <= popcount(mask_in[k % 10]);
          end
        end
        if (in_start) begin
          state <= table_valid ? RECV : ERR;
          decode_done <= 1'b0;
          decode_error <= !table_valid;
          if (table_valid) begin
            sh <= '0;
            cnt <= '0;
            sym_count <= '0;
          end
        end
      end else begin
        sh <= fire ? '0 : sh_nx;
        cnt <= cnt_eff;
        if (fire) begin
          sym_out <= idx;
          sym_valid <= 1'b1;
          sym_count <= (sym_count == SYM_MAX) ? sym_count : sym_count + 9'd1;
        end
        if (err) begin
          state <= ERR;
          decode_error <= 1'b1;
        end else if (in_done) begin
          state <= DONE;
          decode_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_huffman_decoding.sv
// tb_huffman_decoding: directed scenarios plus randomized streams checked against a bit-string reference model.
module tb_huffman_decoding;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 0, table_load = 0, in_start = 0, in_valid = 0, in_data = 0, in_gap = 0, in_done = 0;
  logic [8:0] code [10];
  logic [8:0] mask [10];
  logic [3:0] sym_out;
  logic sym_valid, decode_done, decode_error;
  logic [8:0] sym_count;
  int checks = 0, errors = 0;
  int m_state = 0, m_tv = 0, m_val = 0, m_n = 0, m_sym = 0, m_sv = 0, m_cnt = 0;
  int m_code [10];
  int m_len [10];

  huffman_decoding dut (
    .clk(clk), .rst_n(rst_n), .table_load(table_load),
    .code_0(code[0]), .code_1(code[1]), .code_2(code[2]), .code_3(code[3]), .code_4(code[4]),
    .code_5(code[5]), .code_6(code[6]), .code_7(code[7]), .code_8(code[8]), .code_9(code[9]),
    .code_mask_0(mask[0]), .code_mask_1(mask[1]), .code_mask_2(mask[2]), .code_mask_3(mask[3]),
    .code_mask_4(mask[4]), .code_mask_5(mask[5]), .code_mask_6(mask[6]), .code_mask_7(mask[7]),
    .code_mask_8(mask[8]), .code_mask_9(mask[9]),
    .in_start(in_start), .in_valid(in_valid), .in_data(in_data), .in_gap(in_gap), .in_done(in_done),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_count(sym_count),
    .decode_done(decode_done), .decode_error(decode_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: accumulate received bits as (value, length) and compare against each code string.
  task automatic model();
    int old_tv;
    m_sv = 0;
    if (rst_n) begin
      m_state = 0; m_tv = 0; m_val = 0; m_n = 0; m_sym = 0; m_cnt = 0;
      for (int k = 0; k < 10; k++) begin m_code[k] = 0; m_len[k] = 0; end
      return;
    end
    if (m_state != 1) begin
      old_tv = m_tv;
      if (table_load) begin
        m_tv = 1;
        for (int k = 0; k < 10; k++) begin
          m_len[k] = $countones(mask[k]);
          m_code[k] = int'(code[k]) & ((1 << m_len[k]) - 1);
        end
      end
      if (in_start) begin
        if (old_tv != 0) begin m_state = 1; m_val = 0; m_n = 0; m_cnt = 0; end
        else m_state = 3;
      end
      return;
    end
    if (in_valid) begin
      int found = -1;
      m_val = ((m_val << 1) | int'(in_data)) & 511;
      m_n++;
      for (int k = 9; k >= 0; k--)
        if (m_len[k] > 0 && m_len[k] == m_n && m_code[k] == m_val) found = k;
      if (found >= 0) begin
        m_sym = found; m_sv = 1; m_val = 0; m_n = 0;
        if (m_cnt < 511) m_cnt++;
      end else if (m_n == 9) m_state = 3;
    end
    if (m_state == 1 && (in_gap || in_done) && m_n != 0) m_state = 3;
    else if (m_state == 1 && in_done) m_state = 2;
  endtask

  task automatic step(input bit r, input bit ld, input bit st, input bit v, input bit d, input bit g, input bit dn);
    rst_n = r; table_load = ld; in_start = st; in_valid = v; in_data = d; in_gap = g; in_done = dn;
    model();
    @(posedge clk);
    #1;
    check("sym_out", 32'(sym_out), 32'(m_sym));
    check("sym_valid", 32'(sym_valid), 32'(m_sv));
    check("sym_count", 32'(sym_count), 32'(m_cnt));
    check("decode_done", 32'(decode_done), 32'(m_state == 2));
    check("decode_error", 32'(decode_error), 32'(m_state == 3));
    rst_n = 0; table_load = 0; in_start = 0; in_valid = 0; in_data = 0; in_gap = 0; in_done = 0;
  endtask

  task automatic send_bits(input int n, input logic [15:0] b);
    for (int i = n - 1; i >= 0; i--) step(0, 0, 0, 1, b[i], 0, 0);
  endtask

  task automatic table_a();
    for (int k = 0; k < 10; k++) begin code[k] = 9'($urandom_range(0, 511)); mask[k] = '0; end
    code[0] = 9'h0; mask[0] = 9'h1;
    code[1] = 9'h2; mask[1] = 9'h3;
    code[2] = 9'h6; mask[2] = 9'h7;
    code[3] = 9'h7; mask[3] = 9'h7;
    step(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 10; k++) begin code[k] = '0; mask[k] = '0; end
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_count", 32'(sym_count), 0);
    step(0, 0, 1, 0, 0, 0, 0);
    check("start_no_table", 32'(decode_error), 1);
    table_a();
    step(0, 0, 1, 0, 0, 0, 0);
    send_bits(6, 16'b100111);
    step(0, 0, 0, 0, 0, 0, 1);
    check("basic_count", 32'(sym_count), 3);
    check("basic_done", 32'(decode_done), 1);
    step(0, 0, 1, 0, 0, 0, 0);
    send_bits(2, 16'b11);
    step(0, 0, 0, 0, 0, 1, 0);
    check("gap_error", 32'(decode_error), 1);
    check("gap_count", 32'(sym_count), 0);
    for (int k = 0; k < 10; k++) begin code[k] = '0; mask[k] = '0; end
    mask[0] = 9'h3;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    send_bits(8, 16'hff);
    check("ovf_not_yet", 32'(decode_error), 0);
    send_bits(1, 16'h1);
    check("ovf_error", 32'(decode_error), 1);
    table_a();
    step(0, 0, 1, 0, 0, 0, 0);
    send_bits(2, 16'b10);
    step(0, 0, 0, 1, 0, 0, 1);
    check("last_bit_sym", 32'(sym_out), 0);
    check("last_bit_valid", 32'(sym_valid), 1);
    check("last_bit_done", 32'(decode_done), 1);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 515; i++) step(0, 0, 0, 1, 0, 0, 0);
    check("saturate", 32'(sym_count), 511);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    send_bits(2, 16'b11);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_err", 32'(decode_error), 0);
    step(0, 0, 1, 0, 0, 0, 0);
    check("rst_table_cleared", 32'(decode_error), 1);
    for (int c = 0; c < 3000; c++) begin
      bit ld;
      ld = ($urandom_range(0, 39) == 0);
      if (ld)
        for (int k = 0; k < 10; k++) begin
          int len;
          len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 3);
          mask[k] = 9'((1 << len) - 1);
          code[k] = 9'($urandom_range(0, 511));
        end
      step($urandom_range(0, 199) == 0, ld, !ld && $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 24) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/huffman_decoding.md
HUFFMAN_DECODING -- requirements
Module: huffman_decoding

Interface
REQ-001 SHALL have parameter SYMS, default 10, number of code table entries (symbols 0..SYMS-1).
REQ-002 SHALL have parameter CW, default 9, maximum code length and code/mask width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-high; asserted = 1.
REQ-005 SHALL have port table_load  input  1  pulse; latches code_k and code_mask_k.
REQ-006 SHALL have port code_0..code_9  input  9 each  codeword k, right-aligned, MSB transmitted first.
REQ-007 SHALL have port code_mask_0..code_mask_9  input  9 each  ones in bits [len-1:0]; all-zero means unused symbol.
REQ-008 SHALL have port in_start  input  1  pulse; opens a stream.
REQ-009 SHALL have port in_valid  input  1  in_data carries one code bit this cycle.
REQ-010 SHALL have port in_data  input  1  serial code bit.
REQ-011 SHALL have port in_gap  input  1  pulse; codeword boundary marker.
REQ-012 SHALL have port in_done  input  1  pulse; stream end.
REQ-013 SHALL have port sym_out  output  4  decoded symbol index.
REQ-014 SHALL have port sym_valid  output  1  one-cycle strobe qualifying sym_out.
REQ-015 SHALL have port sym_count  output  9  symbols decoded in current stream.
REQ-016 SHALL have port decode_done  output  1  level; stream ended cleanly.
REQ-017 SHALL have port decode_error  output  1  level; stream aborted.

Function
REQ-018 SHALL implement FSM states IDLE, RECV, DONE, ERR.
REQ-019 SHALL set table_valid and store codes, masks and per-entry length (popcount of mask) when table_load is asserted in IDLE, DONE or ERR; table_load in RECV SHALL be ignored.
REQ-020 SHALL go IDLE/DONE/ERR -> RECV on in_start with table_valid = 1, clearing shift register, bit counter, sym_count, decode_done and decode_error.
REQ-021 SHALL go to ERR on in_start with table_valid = 0.
REQ-022 SHALL, in RECV on in_valid, shift in_data into the LSB of a CW-bit shift register and increment the 4-bit bit counter.
REQ-023 SHALL declare a match for entry k when mask_k is non-zero, len_k equals the post-shift count, and the masked shift register equals the masked code_k; the lowest matching k wins.
REQ-024 SHALL, on a match, register sym_out = k and pulse sym_valid in the cycle after the bit is accepted (latency 1), clear the shift register and counter, and increment sym_count.
REQ-025 SHALL saturate sym_count at 511.
REQ-026 SHALL go to ERR when the post-shift count equals CW with no match.
REQ-027 SHALL go to ERR on in_gap while the counter is non-zero after the same-cycle bit; in_gap with counter zero is a no-op.
REQ-028 SHALL process a same-cycle in_valid bit before evaluating in_gap or in_done.
REQ-029 SHALL, on in_done in RECV, go to DONE if the post-bit counter is zero (including a same-cycle match), otherwise ERR.
REQ-030 SHALL, in ERR or DONE, ignore in_valid, in_gap and in_done; only in_start or reset leaves them.
REQ-031 SHALL hold decode_done = 1 only in DONE and decode_error = 1 only in ERR.

Reset
REQ-032 SHALL, on rst_n = 1 at a clock edge (including mid-stream), enter IDLE, clear table_valid, tables, shift register and counter, and drive sym_out = 0, sym_valid = 0, sym_count = 0, decode_done = 0, decode_error = 0.

Structure
REQ-033 SHALL place SYMS, CW, FSM state encoding and the saturation limit in shared package huffman_pkg.
REQ-034 SHALL instantiate one combinational sub-module huffman_code_match (shift register, count, tables -> hit, index).

Verification
REQ-035 SHALL cover: table {0:"0" mask 001, 1:"10" mask 003, 2:"110" mask 007, 3:"111" mask 007, others mask 0}, start, bits 1,0,0,1,1,1, done -> sym_valid strobes with sym_out 1, 0, 3; sym_count = 3; decode_done = 1.
REQ-036 SHALL cover: same table, bits 1,1 then in_gap -> decode_error = 1, no sym_valid.
REQ-037 SHALL cover: table with only 0:"00", nine 1-bits -> decode_error = 1 after the ninth bit.
REQ-038 SHALL cover: in_start before any table_load -> decode_error = 1.
REQ-039 SHALL cover: final bit "0" and in_done in the same cycle -> sym_out 0 strobed, decode_done = 1.
REQ-040 SHALL cover: rst_n asserted after bits 1,1 -> all outputs 0; a subsequent in_start without table_load -> decode_error = 1.
